vip_frame_stream_gen: RTL and testbench



---
 rtl/vip_stream_pkg.sv | 24 ++
 rtl/vip_timing_cnt.sv | 21 ++
 rtl/vip_frame_stream_gen.sv | 163 ++++++++++++++++
 tb/tb_vip_frame_stream_gen.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/vip_stream_pkg.sv
// Shared types and helpers for the VIP pixel-stream transmitter.
package vip_stream_pkg;

  typedef enum logic [2:0] {
    IDLE, VSYNC, VBP, LINE, HBLANK, VFP
  } state_e;

  localparam int STALL_W = 16;

  // Diagonal test ramp; caller truncates to the pixel width.
  function automatic int unsigned ramp_pix(input int unsigned h, input int unsigned l);
    return h + l;
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/vip_timing_cnt.sv
// Loadable down-counter; tc is high while the count sits at zero.
module vip_timing_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         tc
);

  always_ff @(posedge clk) begin
    if (rst)             cnt <= '0;
    else if (load)       cnt <= load_val;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/vip_frame_stream_gen.sv
// VIP pixel-stream frame generator: pulls upstream pixels and emits vsync/href/clken timing.
// Optional diagonal test pattern enabled by defining VIP_STREAM_PATTERN_EN.
module vip_frame_stream_gen
  import vip_stream_pkg::*;
#(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int H_BLANK   = 16,
  parameter int VSYNC_CYC = 4,
  parameter int VBP_CYC   = 32,
  parameter int VFP_CYC   = 32,
  parameter int DATA_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               cfg_pattern,
  input  logic               src_valid,
  input  logic [DATA_W-1:0]  src_data,
  output logic               src_ready,
  output logic               per_frame_vsync,
  output logic               per_frame_href,
  output logic               per_frame_clken,
  output logic [DATA_W-1:0]  per_img_y,
  output logic               frame_done,
  output logic [STALL_W-1:0] stall_cnt
);

  localparam int HW   = $clog2(H_ACTIVE + 1);
  localparam int LW   = $clog2(V_ACTIVE + 1);
  localparam int PMAX = max4(H_BLANK, VSYNC_CYC, VBP_CYC, VFP_CYC);
  localparam int PW   = (PMAX < 2) ? 1 : $clog2(PMAX);

  state_e            state, nxt;
  logic [HW-1:0]     h_cnt;
  logic [LW-1:0]     line_cnt;
  logic              ph_load, ph_tc;
  logic [PW-1:0]     ph_val;
  logic [PW-1:0]     ph_cnt_unused;
  logic              pat_on;
  logic [DATA_W-1:0] pat_pix;
  logic              in_line, accept, last_pix, vsync_entry;

`ifdef VIP_STREAM_PATTERN_EN
  // Pattern select is frozen for the whole frame once vsync starts.
  always_ff @(posedge clk) begin
    if (rst)              pat_on <= 1'b0;
    else if (vsync_entry) pat_on <= cfg_pattern;
  end
  assign pat_pix = DATA_W'(ramp_pix(32'(h_cnt), 32'(line_cnt)));
`else
  logic unused_cfg;
  assign unused_cfg = cfg_pattern;
  assign pat_on     = 1'b0;
  assign pat_pix    = '0;
`endif

  assign in_line     = (state == LINE);
  assign src_ready   = in_line && !pat_on;
  assign accept      = in_line && (pat_on || src_valid);
  assign last_pix    = (h_cnt == HW'(H_ACTIVE - 1));
  assign vsync_entry = (nxt == VSYNC) && (state != VSYNC);

  vip_timing_cnt #(.W(PW)) u_phase (
    .clk      (clk),
    .rst      (rst),
    .load     (ph_load),
    .load_val (ph_val),
    .cnt      (ph_cnt_unused),
    .tc       (ph_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt     = state;
    ph_load = 1'b0;
    ph_val  = '0;
    case (state)
      IDLE: if (enable) begin
        nxt     = VSYNC;
        ph_load = 1'b1;
        ph_val  = PW'(VSYNC_CYC - 1);
      end
      VSYNC: if (ph_tc) begin
        nxt     = VBP;
        ph_load = 1'b1;
        ph_val  = PW'(VBP_CYC - 1);
      end
      VBP: if (ph_tc) nxt = LINE;
      LINE: if (accept && last_pix) begin
        nxt     = HBLANK;
        ph_load = 1'b1;
        ph_val  = PW'(H_BLANK - 1);
      end
      HBLANK: if (ph_tc) begin
        if (line_cnt < LW'(V_ACTIVE)) nxt = LINE;
        else begin
          nxt     = VFP;
          ph_load = 1'b1;
          ph_val  = PW'(VFP_CYC - 1);
        end
      end
      VFP: if (ph_tc) begin
        if (enable) begin
          nxt     = VSYNC;
          ph_load = 1'b1;
          ph_val  = PW'(VSYNC_CYC - 1);
        end else begin
          nxt = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt    <= '0;
      line_cnt <= '0;
    end else begin
      if (vsync_entry)
        line_cnt <= '0;
      else if (accept && last_pix)
        line_cnt <= line_cnt + 1'b1;
      if (vsync_entry)
        h_cnt <= '0;
      else if (accept)
        h_cnt <= last_pix ? '0 : h_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (in_line && !pat_on && !src_valid && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 1'b1;
  end

  // Stream outputs all lag the FSM by one cycle so they stay mutually aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      per_frame_vsync <= 1'b0;
      per_frame_href  <= 1'b0;
      per_frame_clken <= 1'b0;
      per_img_y       <= '0;
      frame_done      <= 1'b0;
    end else begin
      per_frame_vsync <= (state == VSYNC);
      per_frame_href  <= in_line;
      per_frame_clken <= accept;
      frame_done      <= (state == VFP) && ph_tc;
      if (accept)
        per_img_y <= pat_on ? pat_pix : src_data;
      else if (!in_line)
        per_img_y <= '0;
    end
  end

endmodule

// File: tb/tb_vip_frame_stream_gen.sv
// Self-checking bench for vip_frame_stream_gen with a small frame geometry.
module tb_vip_frame_stream_gen;

  localparam int HA = 8, VA = 4, HB = 4, VS = 2, VBPC = 3, VFPC = 2, DW = 8;
  localparam int FRAME_LEN = VS + VBPC + VA * (HA + HB) + VFPC;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          cfg_pattern = 1'b0;
  logic          src_valid = 1'b0;
  logic [DW-1:0] src_data = '0;
  logic          src_ready, per_frame_vsync, per_frame_href, per_frame_clken, frame_done;
  logic [DW-1:0] per_img_y;
  logic [15:0]   stall_cnt;

  vip_frame_stream_gen #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
    .VSYNC_CYC(VS), .VBP_CYC(VBPC), .VFP_CYC(VFPC), .DATA_W(DW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .cfg_pattern     (cfg_pattern),
    .src_valid       (src_valid),
    .src_data        (src_data),
    .src_ready       (src_ready),
    .per_frame_vsync (per_frame_vsync),
    .per_frame_href  (per_frame_href),
    .per_frame_clken (per_frame_clken),
    .per_img_y       (per_img_y),
    .frame_done      (frame_done),
    .stall_cnt       (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    stall_pix;
    int    stall_len;
    int    drop_pix;
  } vec_t;

  int tests = 0, fails = 0;
  logic [DW-1:0] sb[$];
  logic [DW-1:0] cap[$];
  int href_lens[$], gap_lens[$];
  int run_hi, run_lo, vs_cnt, vs_rises, clk_cnt, fd_cnt, cyc, vs_rise_cyc, fd_cyc, inv_err, ready_hi;
  bit prev_href, prev_vs, pat_chk;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clr_stats();
    href_lens.delete(); gap_lens.delete(); cap.delete();
    run_hi = 0; run_lo = 0; vs_cnt = 0; vs_rises = 0; clk_cnt = 0; fd_cnt = 0;
    inv_err = 0; ready_hi = 0; prev_href = 0; prev_vs = 0; vs_rise_cyc = 0; fd_cyc = 0;
  endtask

  // One clock: record the handshake, advance, then sample #1 after the edge.
  task automatic tick();
    bit acc;
    acc = src_valid && src_ready;
    if (acc) sb.push_back(src_data);
    if (src_ready) ready_hi++;
    @(posedge clk); #1;
    cyc++;
    if (acc) src_data = src_data + 1'b1;
    if (per_frame_vsync) vs_cnt++;
    if (per_frame_vsync && !prev_vs) begin vs_rises++; vs_rise_cyc = cyc; end
    prev_vs = per_frame_vsync;
    if (per_frame_href) begin
      if (!prev_href && href_lens.size() > 0) gap_lens.push_back(run_lo);
      run_hi++; run_lo = 0;
    end else begin
      if (prev_href) href_lens.push_back(run_hi);
      run_hi = 0; run_lo++;
      if (per_frame_clken || per_img_y != '0) inv_err++;
    end
    prev_href = per_frame_href;
    if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
    if (per_frame_clken) begin
      clk_cnt++;
      cap.push_back(per_img_y);
      if (!pat_chk) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL pixel_extra: got %0d, expected no pixel", per_img_y);
        end else begin
          check("pixel", per_img_y, sb.pop_front());
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1; enable = 0; src_valid = 0; cfg_pattern = 0;
    tick(); tick();
    rst = 0; src_data = '0;
    sb.delete();
    clr_stats();
  endtask

  task automatic run_frame(input int stall_pix, input int stall_len, input int drop_pix, input int budget);
    int left, n;
    left = stall_len; n = 0;
    enable = 1;
    while (fd_cnt == 0 && n < budget) begin
      if (int'(src_data) == stall_pix && left > 0) begin src_valid = 0; left--; end
      else src_valid = 1;
      if (int'(src_data) == drop_pix) enable = 0;
      tick(); n++;
    end
    check("frame_timeout", (n < budget) ? 1 : 0, 1);
  endtask

  task automatic check_frame(input int stall_len);
    check("vsync_cycles", vs_cnt, VS);
    check("frame_done_count", fd_cnt, 1);
    // vsync output rises one cycle after VSYNC entry
    check("frame_len", fd_cyc - vs_rise_cyc, FRAME_LEN - 1 + stall_len);
    check("href_pulses", href_lens.size(), VA);
    foreach (href_lens[i]) check("href_len", href_lens[i], HA + ((i == 1) ? stall_len : 0));
    check("href_gaps", gap_lens.size(), VA - 1);
    foreach (gap_lens[i]) check("href_gap_len", gap_lens[i], HB);
    check("clken_count", clk_cnt, VA * HA);
    check("pixels_pending", sb.size(), 0);
    check("stall_cnt", stall_cnt, stall_len);
    check("idle_outputs_clean", inv_err, 0);
  endtask

  vec_t vecs[3];

  initial begin
    int r, n;
    vecs[0] = '{name: "plain",   stall_pix: -1, stall_len: 0, drop_pix: -1};
    vecs[1] = '{name: "stall3",  stall_pix: 12, stall_len: 3, drop_pix: -1};
    vecs[2] = '{name: "drop_en", stall_pix: -1, stall_len: 0, drop_pix: 3};
    cyc = 0; pat_chk = 0;

    do_reset();
    check("rst_vsync", per_frame_vsync, 0);
    check("rst_href", per_frame_href, 0);
    check("rst_clken", per_frame_clken, 0);
    check("rst_y", per_img_y, 0);
    check("rst_done", frame_done, 0);
    check("rst_stall", stall_cnt, 0);
    check("rst_ready", src_ready, 0);

    for (int v = 0; v < 3; v++) begin
      do_reset();
      run_frame(vecs[v].stall_pix, vecs[v].stall_len, vecs[v].drop_pix, 300);
      check_frame(vecs[v].stall_len);
      if (vecs[v].drop_pix >= 0) begin
        r = vs_rises; ready_hi = 0;
        repeat (20) tick();
        check("no_restart", vs_rises, r);
        check("idle_ready", ready_hi, 0);
      end
    end

    // Reset in the middle of the third line aborts the frame cleanly.
    do_reset();
    enable = 1; src_valid = 1; n = 0;
    while (int'(src_data) != 20 && n < 300) begin tick(); n++; end
    check("reach_line3", src_data, 20);
    rst = 1;
    tick();
    check("abort_vsync", per_frame_vsync, 0);
    check("abort_href", per_frame_href, 0);
    check("abort_clken", per_frame_clken, 0);
    check("abort_y", per_img_y, 0);
    check("abort_ready", src_ready, 0);
    rst = 0; enable = 0; src_valid = 0; src_data = '0;
    sb.delete(); clr_stats();
    repeat (5) tick();
    check("abort_no_done", fd_cnt, 0);
    check("abort_no_vsync", vs_rises, 0);
    clr_stats();
    run_frame(-1, 0, -1, 300);
    check_frame(0);

`ifdef VIP_STREAM_PATTERN_EN
    do_reset();
    pat_chk = 1; cfg_pattern = 1; enable = 1; src_valid = 1; n = 0;
    while (fd_cnt < 2 && n < 300) begin tick(); n++; end
    check("pat_frames", fd_cnt, 2);
    check("pat_ready_low", ready_hi, 0);
    check("pat_pixels", cap.size(), 2 * VA * HA);
    foreach (cap[i]) check("pat_pix", cap[i], ((i % HA) + ((i / HA) % VA)) & 8'hFF);
    pat_chk = 0; cfg_pattern = 0;
`endif

    // Stall saturation: the line never receives data.
    do_reset();
    enable = 1; src_valid = 0;
    repeat (70010) tick();
    check("stall_saturate", stall_cnt, 16'hFFFF);
    check("stall_href_held", per_frame_href, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
